mem_wb_stage: RTL and testbench

//  MEM->WB pipeline boundary of the 5-stage MIPS core, directly downstream of DM.

---
 rtl/mem_wb_stage_pkg.sv | 17 +
 rtl/mem_wb_stage_load_ext.sv | 36 +++
 rtl/mem_wb_stage.sv | 92 +++++++++
 tb/tb_mem_wb_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM/WB encodings: load types and write-back source selects.
// The controller and EX/MEM stage use the same constants.
package mem_wb_stage_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC8 = 2'd2;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Sub-word load alignment and sign/zero extension of the DM read word.
// Lane order matches DM stores: addr_lo[1]=1 selects the upper half.
module mem_wb_stage_load_ext
    import mem_wb_stage_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        ld_type,
    output logic [WORD_W-1:0] ext
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Unknown load types fall back to a full-word load.
    always_comb begin
        case (ld_type)
            LD_H:    ext = {{16{w_half[15]}}, w_half};
            LD_HU:   ext = {16'd0, w_half};
            LD_B:    ext = {{24{w_byte[7]}}, w_byte};
            LD_BU:   ext = {24'd0, w_byte};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: selects the GRF write-back value, registers it with
// control for the WB stage, and counts retired instructions.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_m,
    input  logic [DATA_W-1:0] pc_m,
    input  logic [DATA_W-1:0] alu_m,
    input  logic [DATA_W-1:0] rdata_m,
    input  logic [2:0]        ld_type_m,
    input  logic [1:0]        wb_sel_m,
    input  logic              we_m,
    input  logic [RA_W-1:0]   wa_m,
    output logic              valid_w,
    output logic [DATA_W-1:0] pc_w,
    output logic              we_w,
    output logic [RA_W-1:0]   wa_w,
    output logic [DATA_W-1:0] wd_w,
    output logic [CNT_W-1:0]  retired
);

    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_wd;
    logic              w_we;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic              r_we;
    logic [RA_W-1:0]   r_wa;
    logic [DATA_W-1:0] r_wd;
    logic [CNT_W-1:0]  r_retired;

    mem_wb_stage_load_ext u_load_ext (
        .rdata   (rdata_m),
        .addr_lo (alu_m[1:0]),
        .ld_type (ld_type_m),
        .ext     (w_ld_data)
    );

    always_comb begin
        case (wb_sel_m)
            WB_MEM:  w_wd = w_ld_data;
            WB_PC8:  w_wd = pc_m + DATA_W'(8);
            default: w_wd = alu_m;
        endcase
    end

    // $0 is hard-wired zero, and bubbles must never write the GRF.
    assign w_we = we_m && valid_m && (wa_m != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_we      <= 1'b0;
            r_wa      <= '0;
            r_wd      <= '0;
            r_retired <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_we    <= 1'b0;
            r_wa    <= '0;
            r_wd    <= '0;
        end else if (!stall) begin
            r_valid <= valid_m;
            r_pc    <= pc_m;
            r_we    <= w_we;
            r_wa    <= wa_m;
            r_wd    <= w_wd;
            if (valid_m) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign valid_w = r_valid;
    assign pc_w    = r_pc;
    assign we_w    = r_we;
    assign wa_w    = r_wa;
    assign wd_w    = r_wd;
    assign retired = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a second instance with CNT_W=4 covers counter wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_m, we_m;
    logic [31:0] pc_m, alu_m, rdata_m;
    logic [2:0]  ld_type_m;
    logic [1:0]  wb_sel_m;
    logic [4:0]  wa_m;

    logic        valid_w, we_w;
    logic [31:0] pc_w, wd_w, retired;
    logic [4:0]  wa_w;

    logic        valid_w4, we_w4;
    logic [31:0] pc_w4, wd_w4;
    logic [4:0]  wa_w4;
    logic [3:0]  retired4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_m(valid_m),
        .pc_m(pc_m), .alu_m(alu_m), .rdata_m(rdata_m), .ld_type_m(ld_type_m),
        .wb_sel_m(wb_sel_m), .we_m(we_m), .wa_m(wa_m), .valid_w(valid_w), .pc_w(pc_w),
        .we_w(we_w), .wa_w(wa_w), .wd_w(wd_w), .retired(retired)
    );

    mem_wb_stage #(.CNT_W(4)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_m(valid_m),
        .pc_m(pc_m), .alu_m(alu_m), .rdata_m(rdata_m), .ld_type_m(ld_type_m),
        .wb_sel_m(wb_sel_m), .we_m(we_m), .wa_m(wa_m), .valid_w(valid_w4), .pc_w(pc_w4),
        .we_w(we_w4), .wa_w(wa_w4), .wd_w(wd_w4), .retired(retired4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ld, input logic [1:0] sel, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [4:0] wa);
        valid_m   = 1'b1;
        we_m      = 1'b1;
        ld_type_m = ld;
        wb_sel_m  = sel;
        pc_m      = pc;
        alu_m     = alu;
        wa_m      = wa;
    endtask

    logic [2:0]  ld_tab  [6] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0};
    logic [1:0]  b_tab   [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3};
    logic [31:0] exp_tab [6] = '{32'hFFFF_FFA1, 32'h0000_00F0, 32'hFFFF_FF87,
                                 32'hFFFF_8765, 32'h0000_F0A1, 32'h8765_F0A1};

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stall     = 1'($urandom);
            flush     = 1'($urandom);
            valid_m   = 1'($urandom);
            we_m      = 1'($urandom);
            pc_m      = $urandom;
            alu_m     = $urandom;
            rdata_m   = $urandom;
            ld_type_m = 3'($urandom);
            wb_sel_m  = 2'($urandom);
            wa_m      = 5'($urandom);
            step();
        end
        check("rst_valid", {31'd0, valid_w}, 32'd0);
        check("rst_pc", pc_w, 32'd0);
        check("rst_we", {31'd0, we_w}, 32'd0);
        check("rst_wa", {27'd0, wa_w}, 32'd0);
        check("rst_wd", wd_w, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_retired4", {28'd0, retired4}, 32'd0);

        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        rdata_m = 32'h8765_F0A1;
        for (int i = 0; i < 6; i++) begin
            drive(ld_tab[i], 2'd1, 32'h0000_1000, {30'h40, b_tab[i]}, 5'd2);
            step();
            check($sformatf("load%0d_wd", i), wd_w, exp_tab[i]);
        end
        check("load_retired", retired, 32'd6);

        drive(3'd7, 2'd1, 32'h0, 32'h0000_0102, 5'd3);
        step();
        check("ld_undef_wd", wd_w, 32'h8765_F0A1);
        drive(3'd0, 2'd3, 32'h0, 32'h0000_ABCD, 5'd3);
        step();
        check("sel3_wd", wd_w, 32'h0000_ABCD);

        drive(3'd0, 2'd2, 32'h0000_3000, 32'h0000_0055, 5'd31);
        step();
        check("link_wd", wd_w, 32'h0000_3008);
        check("link_wa", {27'd0, wa_w}, 32'd31);
        check("link_we", {31'd0, we_w}, 32'd1);
        check("link_pc", pc_w, 32'h0000_3000);
        check("link_retired", retired, 32'd9);

        drive(3'd0, 2'd2, 32'hFFFF_FFFC, 32'h0, 5'd4);
        step();
        check("pc8_wrap_wd", wd_w, 32'h0000_0004);

        drive(3'd0, 2'd0, 32'h0000_2000, 32'd5, 5'd0);
        step();
        check("zero_we", {31'd0, we_w}, 32'd0);
        check("zero_valid", {31'd0, valid_w}, 32'd1);
        check("zero_wd", wd_w, 32'd5);
        check("zero_retired", retired, 32'd11);

        drive(3'd0, 2'd0, 32'h0000_0040, 32'h0000_1234, 5'd7);
        we_m = 1'b0;
        step();
        check("nowe_we", {31'd0, we_w}, 32'd0);
        drive(3'd0, 2'd0, 32'h0000_0040, 32'h0000_1234, 5'd7);
        step();
        check("A_wd", wd_w, 32'h0000_1234);
        check("A_retired", retired, 32'd13);
        drive(3'd0, 2'd0, 32'h0000_0044, 32'h0000_DEAD, 5'd9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_wd", i), wd_w, 32'h0000_1234);
            check($sformatf("stall%0d_wa", i), {27'd0, wa_w}, 32'd7);
            check($sformatf("stall%0d_pc", i), pc_w, 32'h0000_0040);
            check($sformatf("stall%0d_retired", i), retired, 32'd13);
        end
        flush = 1'b1;
        step();
        check("flush_valid", {31'd0, valid_w}, 32'd0);
        check("flush_we", {31'd0, we_w}, 32'd0);
        check("flush_wa", {27'd0, wa_w}, 32'd0);
        check("flush_wd", wd_w, 32'd0);
        check("flush_pc", pc_w, 32'd0);
        check("flush_retired", retired, 32'd13);

        flush = 1'b0;
        stall = 1'b0;
        valid_m = 1'b0;
        step();
        check("bubble_valid", {31'd0, valid_w}, 32'd0);
        check("bubble_we", {31'd0, we_w}, 32'd0);
        check("bubble_retired", retired, 32'd13);

        drive(3'd0, 2'd0, 32'h0000_0050, 32'h0000_0077, 5'd8);
        step();
        stall = 1'b1;
        reset = 1'b1;
        step();
        check("rst_stall_wd", wd_w, 32'd0);
        check("rst_stall_valid", {31'd0, valid_w}, 32'd0);
        check("rst_stall_retired", retired, 32'd0);

        reset = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(3'd0, 2'd0, 32'(i * 4), 32'(i), 5'd1);
            step();
        end
        check("wrap_retired4", {28'd0, retired4}, 32'd1);
        check("wrap_retired32", retired, 32'd17);
        valid_m = 1'b0;
        step();
        step();
        check("wrap_bubble4", {28'd0, retired4}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
